// File: rtl/arm_rf_pkg.sv
// ============================================================================
// arm_rf_pkg : shared widths, PC index and types for the ARM register file
// Revision   : 1.0
// ============================================================================
`default_nettype none

package arm_rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_NREGS  = 16;
  localparam int RF_ADDR_W = $clog2(RF_NREGS);
  localparam int RF_PC_IDX = RF_NREGS - 1;

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;
  typedef logic [RF_DATA_W-1:0] reg_data_t;

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// rf_scoreboard : per-register busy bits, issue sets / writeback clears
// Revision      : 1.0
// ============================================================================
`default_nettype none

module rf_scoreboard
  import arm_rf_pkg::*;
#(
  parameter int NREGS  = RF_NREGS,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_we,
  input  logic [ADDR_W-1:0] iss_wa,
  input  logic [NREGS-1:0]  clr,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] r_busy;

  // The PC entry is excluded so its busy bit can never be set.
  always_comb begin
    w_set = '0;
    for (int r = 0; r < NREGS - 1; r++) begin
      if (iss_we && (iss_wa == ADDR_W'(r))) begin
        w_set[r] = 1'b1;
      end
    end
  end

  // A newly issued producer outranks a same-cycle writeback of the old one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_set | (r_busy & ~clr);
    end
  end

  assign busy = r_busy;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp : multi-port ARM register file with busy scoreboard
//              (REGFILE_BYPASS_EN enables write-through reads)
// Revision   : 1.0
// ============================================================================
`default_nettype none

module regfile_mp
  import arm_rf_pkg::*;
#(
  parameter  int DATA_W = RF_DATA_W,
  parameter  int NREGS  = RF_NREGS,
  parameter  int NRD    = 3,
  parameter  int NWR    = 2,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] wa,
  input  logic [NWR*DATA_W-1:0] wd,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rd_busy,
  input  logic [DATA_W-1:0]     r15,
  input  logic                  iss_we,
  input  logic [ADDR_W-1:0]     iss_wa
);

  localparam int PC_IDX = NREGS - 1;

  logic [DATA_W-1:0]             r_rf [NREGS-1];
  logic [NREGS-1:0]              w_wr_en;
  logic [NREGS-1:0][DATA_W-1:0]  w_wr_data;
  logic [NREGS-1:0]              w_busy;

  // Ascending port order lets the highest-index port win a collision.
  always_comb begin
    w_wr_en   = '0;
    w_wr_data = '0;
    for (int j = 0; j < NWR; j++) begin
      for (int r = 0; r < PC_IDX; r++) begin
        if (we[j] && (wa[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          w_wr_en[r]   = 1'b1;
          w_wr_data[r] = wd[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < PC_IDX; r++) begin
        r_rf[r] <= '0;
      end
    end else begin
      for (int r = 0; r < PC_IDX; r++) begin
        if (w_wr_en[r]) begin
          r_rf[r] <= w_wr_data[r];
        end
      end
    end
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk    (clk),
    .reset  (reset),
    .iss_we (iss_we),
    .iss_wa (iss_wa),
    .clr    (w_wr_en),
    .busy   (w_busy)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;
    logic              w_rd_busy;

    assign w_ra = ra[i*ADDR_W +: ADDR_W];

    always_comb begin
      w_rd      = '0;
      w_rd_busy = 1'b0;
      if (w_ra == ADDR_W'(PC_IDX)) begin
        w_rd = r15;
      end else if (int'(w_ra) < PC_IDX) begin
        w_rd      = r_rf[w_ra];
        w_rd_busy = w_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en[w_ra]) begin
          w_rd      = w_wr_data[w_ra];
          w_rd_busy = iss_we && (iss_wa == w_ra);
        end
`endif
      end
    end

    assign rd[i*DATA_W +: DATA_W] = w_rd;
    assign rd_busy[i]             = w_rd_busy;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// tb_regfile_mp : directed stimulus with queued expectations and a monitor
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int NRD = 3;
  localparam int NWR = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NWR-1:0]     we;
  logic [NWR*AW-1:0]  wa;
  logic [NWR*DW-1:0]  wd;
  logic [NRD*AW-1:0]  ra;
  logic [NRD*DW-1:0]  rd;
  logic [NRD-1:0]     rd_busy;
  logic [DW-1:0]      r15;
  logic               iss_we;
  logic [AW-1:0]      iss_wa;

  regfile_mp #(.DATA_W(DW), .NREGS(16), .NRD(NRD), .NWR(NWR)) dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .ra      (ra),
    .rd      (rd),
    .rd_busy (rd_busy),
    .r15     (r15),
    .iss_we  (iss_we),
    .iss_wa  (iss_wa)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] data;
    logic        busy;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: read ports are combinational, so results are sampled mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] got_d;
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s stale expectation cycle %0d now %0d", e.name, e.cyc, cyc);
      end else begin
        got_d = rd[e.port*DW +: DW];
        if (got_d !== e.data) begin
          errors++;
          $display("FAIL %s rd[%0d] got %h want %h", e.name, e.port, got_d, e.data);
        end
        checks++;
        if (rd_busy[e.port] !== e.busy) begin
          errors++;
          $display("FAIL %s rd_busy[%0d] got %b want %b", e.name, e.port, rd_busy[e.port], e.busy);
        end
      end
    end
  end

  task automatic idle();
    we     = '0;
    wa     = '0;
    wd     = '0;
    iss_we = 1'b0;
    iss_wa = '0;
  endtask

  task automatic wr(input int j, input int a, input logic [31:0] d);
    we[j]            = 1'b1;
    wa[j*AW +: AW]   = AW'(a);
    wd[j*DW +: DW]   = d;
  endtask

  task automatic iss(input int a);
    iss_we = 1'b1;
    iss_wa = AW'(a);
  endtask

  task automatic chk(input int p, input int a, input logic [31:0] d,
                     input logic b, input string name);
    exp_t e;
    ra[p*AW +: AW] = AW'(a);
    e.cyc  = cyc;
    e.port = p;
    e.data = d;
    e.busy = b;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ra    = '0;
    r15   = 32'h108;
    idle();
    repeat (2) tick();
    reset = 1'b0;

    // Some activity before reset so it has state to clear
    wr(0, 1, 32'h11); wr(1, 9, 32'h99); iss(4);
    tick(); idle();
    chk(0, 1, 32'h11, 1'b0, "pre_r1");
    chk(1, 9, 32'h99, 1'b0, "pre_r9");
    chk(2, 4, 32'h0,  1'b1, "pre_busy4");
    reset = 1'b1; wr(0, 2, 32'h5); iss(6);
    tick(); idle(); reset = 1'b0;
    for (int a = 0; a < 15; a++) begin
      chk(0, a, 32'h0, 1'b0, "reset_reg");
      chk(1, 15, 32'h108, 1'b0, "reset_pc");
      tick();
    end

    // Basic write/read and PC read
    wr(0, 3, 32'h1234_5678);
    tick(); idle();
    chk(0, 3, 32'h1234_5678, 1'b0, "wr_r3");
    chk(1, 15, 32'h108, 1'b0, "rd_pc");
    tick();

    // Same-address collision: port 1 wins
    wr(0, 5, 32'hAAAA); wr(1, 5, 32'hBBBB);
    tick(); idle();
    chk(0, 5, 32'hBBBB, 1'b0, "collide_r5");
    tick();

    // Scoreboard set / clear / set-wins / clear of idle reg
    iss(7);
    tick(); idle();
    chk(0, 7, 32'h0, 1'b1, "busy_set");
    tick();
    wr(0, 7, 32'h77);
    tick(); idle();
    chk(0, 7, 32'h77, 1'b0, "busy_clr");
    tick();
    iss(7); wr(1, 7, 32'h78);
    tick(); idle();
    chk(0, 7, 32'h78, 1'b1, "set_wins");
    tick();
    wr(0, 8, 32'h88);
    tick(); idle();
    chk(0, 8, 32'h88, 1'b0, "clr_idle");
    tick();
    iss(15);
    tick(); idle();
    chk(0, 15, 32'h108, 1'b0, "pc_never_busy");
    tick();

    // PC writes are dropped
    wr(0, 15, 32'hDEAD);
    tick(); idle(); r15 = 32'h200;
    chk(0, 15, 32'h200, 1'b0, "pc_wr_drop");
    chk(1, 3, 32'h1234_5678, 1'b0, "pc_wr_r3");
    chk(2, 7, 32'h78, 1'b1, "pc_wr_r7");
    tick();

    // Same-cycle write and read
    iss(2);
    tick(); idle();
    wr(0, 2, 32'h55);
`ifdef REGFILE_BYPASS_EN
    chk(0, 2, 32'h55, 1'b0, "same_cyc_rd");
`else
    chk(0, 2, 32'h0, 1'b1, "same_cyc_rd");
`endif
    tick(); idle();
    wr(0, 2, 32'h66); wr(1, 2, 32'h67); iss(2);
`ifdef REGFILE_BYPASS_EN
    chk(0, 2, 32'h67, 1'b1, "same_cyc_collide");
`else
    chk(0, 2, 32'h55, 1'b0, "same_cyc_collide");
`endif
    tick(); idle();
    chk(0, 2, 32'h67, 1'b1, "after_collide");
    tick();

    repeat (2) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached want finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
